pipe_ctrl: RTL and testbench

//  Pipeline sequencer for the 5-stage core; sits beside the hazard detect unit and owns all stage stall/flush controls.

---
 rtl/pipe_ctrl_pkg.sv | 58 +++++
 rtl/pipe_ctrl_perf.sv | 25 ++
 rtl/pipe_ctrl.sv | 147 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline sequencer: FSM state encodings and the bundled stall/flush control word.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    PIPE_CTRL_RUN        = 2'd0,
    PIPE_CTRL_LSU_WAIT   = 2'd1,
    PIPE_CTRL_MDU_WAIT   = 2'd2,
    PIPE_CTRL_TRAP_DRAIN = 2'd3
  } pipe_state_e;

  typedef struct packed {
    logic pc_stall;
    logic if2id_stall;
    logic id2ex_stall;
    logic ex2mem_stall;
    logic if_flush;
    logic id_flush;
    logic ex_flush;
    logic mem_flush;
    logic trap_redirect;
    logic mdu_kill;
  } ctrl_t;

  // Wide enough for TRAP_FLUSH_CYCLES up to 15.
  localparam int DRAIN_CNT_W = 4;

  // Whole pipe frozen while the data bus is busy; MEM/WB gets a bubble.
  function automatic ctrl_t lsu_hold_ctrl();
    ctrl_t c;
    c = '0;
    c.pc_stall     = 1'b1;
    c.if2id_stall  = 1'b1;
    c.id2ex_stall  = 1'b1;
    c.ex2mem_stall = 1'b1;
    c.mem_flush    = 1'b1;
    return c;
  endfunction

  function automatic ctrl_t mdu_hold_ctrl();
    ctrl_t c;
    c = '0;
    c.pc_stall    = 1'b1;
    c.if2id_stall = 1'b1;
    c.id2ex_stall = 1'b1;
    c.ex_flush    = 1'b1;
    return c;
  endfunction

  function automatic ctrl_t drain_ctrl();
    ctrl_t c;
    c = '0;
    c.if_flush = 1'b1;
    c.id_flush = 1'b1;
    c.ex_flush = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/pipe_ctrl_perf.sv
// Saturating stall/flush event counters; only present in PIPE_CTRL_PERF_EN builds.
`ifdef PIPE_CTRL_PERF_EN
module pipe_ctrl_perf #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         flush,
  output logic [W-1:0] stall_cycles,
  output logic [W-1:0] flush_events
);

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (stall && (stall_cycles != '1)) stall_cycles <= stall_cycles + 1'b1;
      if (flush && (flush_events != '1)) flush_events <= flush_events + 1'b1;
    end
  end

endmodule
`endif

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: prioritises trap, LSU, MDU, branch and load-use hazards into stall/flush controls.
// Define PIPE_CTRL_PERF_EN to build the saturating stall_cycles/flush_events counters; otherwise they read 0.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned TRAP_FLUSH_CYCLES = 2,
  parameter int unsigned PERF_CNT_W        = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  take_branch,
  input  logic                  load_dependence,
  input  logic                  mdu_req,
  input  logic                  mdu_done,
  input  logic                  lsu_req,
  input  logic                  lsu_ready,
  input  logic                  trap_req,
  output logic                  pc_stall,
  output logic                  if2id_stall,
  output logic                  id2ex_stall,
  output logic                  ex2mem_stall,
  output logic                  if_flush,
  output logic                  id_flush,
  output logic                  ex_flush,
  output logic                  mem_flush,
  output logic                  trap_redirect,
  output logic                  mdu_kill,
  output logic [PERF_CNT_W-1:0] stall_cycles,
  output logic [PERF_CNT_W-1:0] flush_events,
  output logic [1:0]            fsm_state
);

  localparam logic [DRAIN_CNT_W-1:0] DRAIN_LOAD = DRAIN_CNT_W'(TRAP_FLUSH_CYCLES - 1);

  pipe_state_e            state_q, state_d;
  logic [DRAIN_CNT_W-1:0] drain_q, drain_d;
  logic                   pending_q, pending_d;
  ctrl_t                  ctrl, ctrl_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= PIPE_CTRL_RUN;
      drain_q   <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      drain_q   <= drain_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    ctrl      = '0;
    state_d   = state_q;
    drain_d   = drain_q;
    pending_d = pending_q;
    case (state_q)
      PIPE_CTRL_RUN: begin
        if (trap_req || pending_q) begin
          ctrl               = drain_ctrl();
          ctrl.trap_redirect = 1'b1;
          drain_d            = DRAIN_LOAD;
          pending_d          = 1'b0;
          state_d            = PIPE_CTRL_TRAP_DRAIN;
        end else if (lsu_req && !lsu_ready) begin
          ctrl    = lsu_hold_ctrl();
          state_d = PIPE_CTRL_LSU_WAIT;
        end else if (mdu_req && !mdu_done) begin
          ctrl    = mdu_hold_ctrl();
          state_d = PIPE_CTRL_MDU_WAIT;
        end else if (take_branch) begin
          ctrl.if_flush = 1'b1;
          ctrl.id_flush = 1'b1;
        end else if (load_dependence) begin
          ctrl.pc_stall    = 1'b1;
          ctrl.if2id_stall = 1'b1;
          ctrl.id_flush    = 1'b1;
        end
      end
      PIPE_CTRL_LSU_WAIT: begin
        // The bus access cannot be aborted, so a trap here is remembered and taken from RUN.
        if (trap_req) pending_d = 1'b1;
        if (lsu_ready) state_d = PIPE_CTRL_RUN;
        else           ctrl    = lsu_hold_ctrl();
      end
      PIPE_CTRL_MDU_WAIT: begin
        if (trap_req) begin
          ctrl               = drain_ctrl();
          ctrl.trap_redirect = 1'b1;
          ctrl.mdu_kill      = 1'b1;
          drain_d            = DRAIN_LOAD;
          state_d            = PIPE_CTRL_TRAP_DRAIN;
        end else if (mdu_done) begin
          state_d = PIPE_CTRL_RUN;
        end else begin
          ctrl = mdu_hold_ctrl();
        end
      end
      PIPE_CTRL_TRAP_DRAIN: begin
        ctrl = drain_ctrl();
        if (trap_req) begin
          ctrl.trap_redirect = 1'b1;
          drain_d            = DRAIN_LOAD;
        end else if (drain_q == '0) begin
          state_d = PIPE_CTRL_RUN;
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end
      default: state_d = PIPE_CTRL_RUN;
    endcase
  end

  assign ctrl_o        = rst ? '0 : ctrl;
  assign pc_stall      = ctrl_o.pc_stall;
  assign if2id_stall   = ctrl_o.if2id_stall;
  assign id2ex_stall   = ctrl_o.id2ex_stall;
  assign ex2mem_stall  = ctrl_o.ex2mem_stall;
  assign if_flush      = ctrl_o.if_flush;
  assign id_flush      = ctrl_o.id_flush;
  assign ex_flush      = ctrl_o.ex_flush;
  assign mem_flush     = ctrl_o.mem_flush;
  assign trap_redirect = ctrl_o.trap_redirect;
  assign mdu_kill      = ctrl_o.mdu_kill;
  assign fsm_state     = state_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [PERF_CNT_W-1:0] stall_cnt, flush_cnt;

  pipe_ctrl_perf #(.W(PERF_CNT_W)) u_perf (
    .clk          (clk),
    .rst          (rst),
    .stall        (ctrl_o.pc_stall),
    .flush        (ctrl_o.if_flush),
    .stall_cycles (stall_cnt),
    .flush_events (flush_cnt)
  );

  // Counters clear synchronously; mask them so they read 0 for the whole reset window.
  assign stall_cycles = rst ? '0 : stall_cnt;
  assign flush_events = rst ? '0 : flush_cnt;
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed hazard scenarios plus randomized traffic against a behavioural model.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int TFC = 2;
  localparam int PCW = 32;

  // Control word bits: {pc, if2id, id2ex, ex2mem stalls, if, id, ex, mem flushes, redirect, kill}
  localparam logic [9:0] B_PC    = 10'b10_0000_0000;
  localparam logic [9:0] B_IF2ID = 10'b01_0000_0000;
  localparam logic [9:0] B_ID2EX = 10'b00_1000_0000;
  localparam logic [9:0] B_EX2M  = 10'b00_0100_0000;
  localparam logic [9:0] B_IFF   = 10'b00_0010_0000;
  localparam logic [9:0] B_IDF   = 10'b00_0001_0000;
  localparam logic [9:0] B_EXF   = 10'b00_0000_1000;
  localparam logic [9:0] B_MEMF  = 10'b00_0000_0100;
  localparam logic [9:0] B_REDIR = 10'b00_0000_0010;
  localparam logic [9:0] B_KILL  = 10'b00_0000_0001;

  localparam logic [9:0] C_LSU   = B_PC | B_IF2ID | B_ID2EX | B_EX2M | B_MEMF;
  localparam logic [9:0] C_MDU   = B_PC | B_IF2ID | B_ID2EX | B_EXF;
  localparam logic [9:0] C_DRAIN = B_IFF | B_IDF | B_EXF;
  localparam logic [9:0] C_TRAP  = C_DRAIN | B_REDIR;
  localparam logic [9:0] C_BR    = B_IFF | B_IDF;
  localparam logic [9:0] C_LD    = B_PC | B_IF2ID | B_IDF;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic take_branch = 0, load_dependence = 0, mdu_req = 0, mdu_done = 0;
  logic lsu_req = 0, lsu_ready = 0, trap_req = 0;
  logic pc_stall, if2id_stall, id2ex_stall, ex2mem_stall;
  logic if_flush, id_flush, ex_flush, mem_flush, trap_redirect, mdu_kill;
  logic [PCW-1:0] stall_cycles, flush_events;
  logic [1:0] fsm_state;
  logic [9:0] dut_ctrl;

  pipe_ctrl #(.TRAP_FLUSH_CYCLES(TFC), .PERF_CNT_W(PCW)) dut (
    .clk(clk), .rst(rst),
    .take_branch(take_branch), .load_dependence(load_dependence),
    .mdu_req(mdu_req), .mdu_done(mdu_done),
    .lsu_req(lsu_req), .lsu_ready(lsu_ready), .trap_req(trap_req),
    .pc_stall(pc_stall), .if2id_stall(if2id_stall), .id2ex_stall(id2ex_stall),
    .ex2mem_stall(ex2mem_stall), .if_flush(if_flush), .id_flush(id_flush),
    .ex_flush(ex_flush), .mem_flush(mem_flush), .trap_redirect(trap_redirect),
    .mdu_kill(mdu_kill), .stall_cycles(stall_cycles), .flush_events(flush_events),
    .fsm_state(fsm_state)
  );

  assign dut_ctrl = {pc_stall, if2id_stall, id2ex_stall, ex2mem_stall,
                     if_flush, id_flush, ex_flush, mem_flush, trap_redirect, mdu_kill};

  int n_checks = 0;
  int n_fail   = 0;
  logic [9:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // driver tasks: drive sets inputs and settles; step advances one clock
  task automatic drive(input logic br, input logic ld, input logic mq, input logic md,
                       input logic lq, input logic lr, input logic tr);
    take_branch = br; load_dependence = ld; mdu_req = mq; mdu_done = md;
    lsu_req = lq; lsu_ready = lr; trap_req = tr;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: which wait the pipe is in, cycles of drain left, and an owed trap.
  bit             m_lsu_busy = 0, m_mdu_busy = 0, m_trap_owed = 0;
  int             m_drain_left = 0;
  logic [PCW-1:0] m_stall_cnt = '0, m_flush_cnt = '0;

  always @(negedge clk) begin : compare
    logic [9:0]  e;
    pipe_state_e es;
    es = (m_drain_left > 0) ? PIPE_CTRL_TRAP_DRAIN :
         m_lsu_busy         ? PIPE_CTRL_LSU_WAIT   :
         m_mdu_busy         ? PIPE_CTRL_MDU_WAIT   : PIPE_CTRL_RUN;
    e = '0;
    if (rst) begin
      e = '0;
    end else if (m_drain_left > 0) begin
      e = C_DRAIN;
      if (trap_req) begin
        e = C_TRAP;
        m_drain_left = TFC;
      end else begin
        m_drain_left = m_drain_left - 1;
      end
    end else if (m_lsu_busy) begin
      if (trap_req) m_trap_owed = 1;
      if (lsu_ready) m_lsu_busy = 0;
      else           e = C_LSU;
    end else if (m_mdu_busy) begin
      if (trap_req) begin
        e = C_TRAP | B_KILL;
        m_mdu_busy = 0;
        m_drain_left = TFC;
      end else if (mdu_done) begin
        m_mdu_busy = 0;
      end else begin
        e = C_MDU;
      end
    end else if (trap_req || m_trap_owed) begin
      e = C_TRAP;
      m_trap_owed = 0;
      m_drain_left = TFC;
    end else if (lsu_req && !lsu_ready) begin
      e = C_LSU;
      m_lsu_busy = 1;
    end else if (mdu_req && !mdu_done) begin
      e = C_MDU;
      m_mdu_busy = 1;
    end else if (take_branch) begin
      e = C_BR;
    end else if (load_dependence) begin
      e = C_LD;
    end

    exp_q.push_back(e);
    check("ctrl", dut_ctrl, exp_q.pop_front());
    check("state", fsm_state, es);
`ifdef PIPE_CTRL_PERF_EN
    check("stall_cycles", stall_cycles, rst ? '0 : m_stall_cnt);
    check("flush_events", flush_events, rst ? '0 : m_flush_cnt);
`else
    check("stall_cycles", stall_cycles, 0);
    check("flush_events", flush_events, 0);
`endif

    if (rst) begin
      m_lsu_busy = 0; m_mdu_busy = 0; m_trap_owed = 0; m_drain_left = 0;
      m_stall_cnt = '0; m_flush_cnt = '0;
    end else begin
      if (e[9] && m_stall_cnt != '1) m_stall_cnt = m_stall_cnt + 1;
      if (e[5] && m_flush_cnt != '1) m_flush_cnt = m_flush_cnt + 1;
    end
  end

  initial begin : watchdog
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : stimulus
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      drive(1, 1, 1, 0, 1, 0, 1);
      check("reset_ctrl", dut_ctrl, 0);
      check("reset_cnt", stall_cycles, 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;

    // LSU wait: 3 stalled cycles, then release
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 1, 0, 0); check("lsu_stall", dut_ctrl, C_LSU); step();
    end
    drive(0, 0, 0, 0, 1, 1, 0); check("lsu_exit", dut_ctrl, 0); step();
    drive(0, 0, 0, 0, 0, 0, 0); check("lsu_state", fsm_state, PIPE_CTRL_RUN);
`ifdef PIPE_CTRL_PERF_EN
    check("stall_cnt3", stall_cycles, 3);
`else
    check("stall_cnt_off", stall_cycles, 0);
`endif
    step();

    // load-use for one cycle
    drive(0, 1, 0, 0, 0, 0, 0); check("ld_use", dut_ctrl, C_LD); step();
    drive(0, 0, 0, 0, 0, 0, 0); check("ld_use_after", dut_ctrl, 0);
    check("ld_use_state", fsm_state, PIPE_CTRL_RUN); step();

    // branch outranks load-use
    drive(1, 1, 0, 0, 0, 0, 0); check("br_ld", dut_ctrl, C_BR); step();

    // MDU: done on the 5th cycle
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, 0, 0, 0, 0); check("mdu_stall", dut_ctrl, C_MDU); step();
    end
    drive(0, 0, 1, 1, 0, 0, 0); check("mdu_done", dut_ctrl, 0); step();
    drive(0, 0, 0, 0, 0, 0, 0); check("mdu_state", fsm_state, PIPE_CTRL_RUN); step();

    // MDU killed by a trap on cycle 2
    drive(0, 0, 1, 0, 0, 0, 0); check("mdu_k_stall", dut_ctrl, C_MDU); step();
    drive(0, 0, 1, 0, 0, 0, 1); check("mdu_kill", dut_ctrl, C_TRAP | B_KILL); step();
    for (int i = 0; i < TFC; i++) begin
      drive(0, 0, 1, 0, 0, 0, 0); check("mdu_k_drain", dut_ctrl, C_DRAIN);
      check("mdu_k_dstate", fsm_state, PIPE_CTRL_TRAP_DRAIN); step();
    end
    drive(0, 0, 0, 0, 0, 0, 0); check("mdu_k_run", dut_ctrl, 0); step();

    // trap during LSU wait, ready two cycles later
    drive(0, 0, 0, 0, 1, 0, 0); check("lt_stall0", dut_ctrl, C_LSU); step();
    drive(0, 0, 0, 0, 1, 0, 1); check("lt_stall1", dut_ctrl, C_LSU); step();
    drive(0, 0, 0, 0, 1, 0, 0); check("lt_stall2", dut_ctrl, C_LSU); step();
    drive(0, 0, 0, 0, 1, 1, 0); check("lt_exit", dut_ctrl, 0); step();
    drive(0, 0, 0, 0, 0, 0, 0); check("lt_redirect", dut_ctrl, C_TRAP); step();
    for (int i = 0; i < TFC; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0); check("lt_drain", dut_ctrl, C_DRAIN); step();
    end
    drive(0, 0, 0, 0, 0, 0, 0); check("lt_run", dut_ctrl, 0); step();

    // trap and lsu_ready in the same cycle
    drive(0, 0, 0, 0, 1, 0, 0); check("sim_stall", dut_ctrl, C_LSU); step();
    drive(0, 0, 0, 0, 1, 1, 1); check("sim_exit", dut_ctrl, 0); step();
    drive(0, 0, 0, 0, 0, 0, 0); check("sim_redirect", dut_ctrl, C_TRAP); step();
    for (int i = 0; i < TFC; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0); check("sim_drain", dut_ctrl, C_DRAIN); step();
    end
    drive(0, 0, 0, 0, 0, 0, 0); check("sim_run", dut_ctrl, 0); step();

    // a new trap inside TRAP_DRAIN restarts the drain
    drive(0, 0, 0, 0, 0, 0, 1); check("re_trap0", dut_ctrl, C_TRAP); step();
    drive(0, 0, 0, 0, 0, 0, 0); check("re_drain0", dut_ctrl, C_DRAIN); step();
    drive(0, 0, 0, 0, 0, 0, 1); check("re_trap1", dut_ctrl, C_TRAP); step();
    for (int i = 0; i < TFC; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0); check("re_drain1", dut_ctrl, C_DRAIN); step();
    end
    drive(0, 0, 0, 0, 0, 0, 0); check("re_run", dut_ctrl, 0); step();

    // reset in the middle of TRAP_DRAIN
    drive(0, 0, 0, 0, 0, 0, 1); check("rd_trap", dut_ctrl, C_TRAP); step();
    rst = 1'b1;
    drive(1, 1, 1, 0, 1, 0, 1); check("rd_rst_ctrl", dut_ctrl, 0);
    check("rd_rst_cnt", flush_events, 0); step();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0); check("rd_ctrl", dut_ctrl, 0);
    check("rd_state", fsm_state, PIPE_CTRL_RUN);
    check("rd_cnt", stall_cycles, 0); step();

    // randomized traffic, checked every cycle by the compare process
    for (int i = 0; i < 3000; i++) begin
      rst             = ($urandom_range(0, 299) == 0);
      take_branch     = ($urandom_range(0, 3) == 0);
      load_dependence = ($urandom_range(0, 3) == 0);
      mdu_req         = ($urandom_range(0, 2) == 0);
      mdu_done        = ($urandom_range(0, 3) == 0);
      lsu_req         = ($urandom_range(0, 2) == 0);
      lsu_ready       = ($urandom_range(0, 1) == 0);
      trap_req        = ($urandom_range(0, 19) == 0);
      step();
    end
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
